// File: rtl/jump_pkg.sv
// Shared definitions for the next-PC sequencer.
//   - JR decode constants (main-control ALUOp for R-type, funct for JR)
//   - FSM state and redirect-kind enums
//   - is_jr(): jump-register decode helper
package jump_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    JR   = 2'd1,
    J    = 2'd2,
    BR   = 2'd3
  } redir_kind_e;

  function automatic logic is_jr(input logic [1:0] aluop, input logic [5:0] funct);
    return (aluop == ALUOP_RTYPE) && (funct == FUNCT_JR);
  endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Combinational redirect-target generator.
// Ports:
//   id_pc         in  32  PC of the instruction in ID
//   rs_data       in  32  rs value (JR target)
//   jump_index    in  26  instr[25:0] (J target field)
//   branch_offset in  16  instr[15:0] (BEQ word offset)
//   kind          in      which redirect is being taken
//   target        out 32  redirect address for that kind
//   misaligned    out  1  JR target had non-zero low bits
module jump_target_calc
  import jump_pkg::*;
(
  input  logic [31:0]  id_pc,
  input  logic [31:0]  rs_data,
  input  logic [25:0]  jump_index,
  input  logic [15:0]  branch_offset,
  input  redir_kind_e  kind,
  output logic [31:0]  target,
  output logic         misaligned
);

  logic [31:0] seq;
  logic [31:0] br_disp;

  assign seq     = id_pc + 32'd4;
  // Sign-extended word offset converted to a byte displacement.
  assign br_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    target = seq;
    unique case (kind)
      JR:      target = {rs_data[31:2], 2'b00};
      J:       target = {seq[31:28], jump_index, 2'b00};
      BR:      target = seq + br_disp;  // wraps modulo 2^32
      default: target = seq;
    endcase
  end

  assign misaligned = (kind == JR) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/jump_sequencer.sv
// Next-PC sequencer for the fetch stage.
// Holds the fetch PC, advances it by 4 on each accepted fetch, and redirects
// it on JR / J / taken BEQ decoded in ID, followed by a flush window of
// FLUSH_CYCLES cycles during which IF/ID squashes wrong-path instructions.
//
// Fetch handshake: pc is a request whenever fetch_valid=1; the request is
// accepted on a rising edge where fetch_valid=1 and imem_ready=1, and only an
// accepted request lets pc step to pc+4. A redirect replaces pc regardless of
// imem_ready; memory sees the new address on its next ready.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   imem_ready                       memory accepts the fetch at pc
//   stall_in                         ID hazard stall (RUN only)
//   id_valid, id_pc, ALUOp, Function,
//   Jump, Branch, Zero, rs_data,
//   jump_index, branch_offset        ID-stage decode inputs
//   pc, fetch_valid                  fetch request
//   flush                            squash IF/ID
//   redirect, jr_taken               one-cycle pulses at the new target
//   err_misaligned                   one-cycle pulse on a misaligned JR
//   dbg_state                        current FSM state
module jump_sequencer
  import jump_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imem_ready,
  input  logic            stall_in,
  input  logic            id_valid,
  input  logic [PC_W-1:0] id_pc,
  input  logic [1:0]      ALUOp,
  input  logic [5:0]      Function,
  input  logic            Jump,
  input  logic            Branch,
  input  logic            Zero,
  input  logic [PC_W-1:0] rs_data,
  input  logic [25:0]     jump_index,
  input  logic [15:0]     branch_offset,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            redirect,
  output logic            jr_taken,
  output logic            err_misaligned,
  output state_e          dbg_state
);

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fv_q;
  logic            redirect_q, redirect_d;
  logic            jr_q, jr_d;
  logic            err_q, err_d;

  redir_kind_e     kind;
  logic [PC_W-1:0] target;
  logic            misaligned;
  logic            dec_en;

  // Decode only in RUN with a real, unstalled ID instruction.
  // Priority JR > J > taken branch.
  assign dec_en = (state_q == RUN) && id_valid && !stall_in;

  always_comb begin
    kind = NONE;
    if (dec_en) begin
      if (is_jr(ALUOp, Function)) kind = JR;
      else if (Jump)              kind = J;
      else if (Branch && Zero)    kind = BR;
    end
  end

  jump_target_calc u_target (
    .id_pc         (id_pc),
    .rs_data       (rs_data),
    .jump_index    (jump_index),
    .branch_offset (branch_offset),
    .kind          (kind),
    .target        (target),
    .misaligned    (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    jr_d       = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (kind != NONE) begin
          pc_d       = target;
          state_d    = FLUSH;
          fcnt_d     = FCNT_INIT;
          redirect_d = 1'b1;
          jr_d       = (kind == JR);
          err_d      = misaligned;
        end else if (fv_q && imem_ready && !stall_in) begin
          pc_d = pc_q + PC_W'(4);
        end
      end
      FLUSH: begin
        // Stall is ignored here: the instruction it refers to is wrong-path.
        if (imem_ready) pc_d = pc_q + PC_W'(4);
        if (fcnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fcnt_q     <= 3'd0;
      pc_q       <= RESET_PC;
      fv_q       <= 1'b0;
      redirect_q <= 1'b0;
      jr_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      pc_q       <= pc_d;
      fv_q       <= 1'b1;
      redirect_q <= redirect_d;
      jr_q       <= jr_d;
      err_q      <= err_d;
    end
  end

  assign pc             = pc_q;
  assign fetch_valid    = fv_q;
  assign flush          = (state_q == FLUSH);
  assign redirect       = redirect_q;
  assign jr_taken       = jr_q;
  assign err_misaligned = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_jump_sequencer.sv
module tb_jump_sequencer;
  import jump_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_ready, stall_in, id_valid;
  logic [31:0] id_pc, rs_data;
  logic [1:0]  ALUOp;
  logic [5:0]  Function;
  logic        Jump, Branch, Zero;
  logic [25:0] jump_index;
  logic [15:0] branch_offset;
  logic [31:0] pc;
  logic        fetch_valid, flush, redirect, jr_taken, err_misaligned;
  state_e      dbg_state;

  jump_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ready     (imem_ready),
    .stall_in       (stall_in),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .ALUOp          (ALUOp),
    .Function       (Function),
    .Jump           (Jump),
    .Branch         (Branch),
    .Zero           (Zero),
    .rs_data        (rs_data),
    .jump_index     (jump_index),
    .branch_offset  (branch_offset),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .flush          (flush),
    .redirect       (redirect),
    .jr_taken       (jr_taken),
    .err_misaligned (err_misaligned),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled and inputs re-driven 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_pc = '0; rs_data = '0; ALUOp = 2'b00; Function = 6'd0;
    Jump = 0; Branch = 0; Zero = 0; jump_index = '0; branch_offset = '0;
  endtask

  task automatic drive_jr(input logic [31:0] rs);
    clr_id();
    id_valid = 1; ALUOp = 2'b10; Function = 6'b001000; rs_data = rs;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic e_fl,
                         input logic e_rd, input logic e_jr, input logic e_err);
    check({tag, ".pc"},  pc, e_pc);
    check({tag, ".fl"},  32'(flush), 32'(e_fl));
    check({tag, ".rd"},  32'(redirect), 32'(e_rd));
    check({tag, ".jr"},  32'(jr_taken), 32'(e_jr));
    check({tag, ".err"}, 32'(err_misaligned), 32'(e_err));
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    rst_n = 0; imem_ready = 1; stall_in = 0;
    clr_id();
    step(); step();
    chk_out("rst", 32'h0, 0, 0, 0, 0);
    check("rst.fv", 32'(fetch_valid), 32'd0);
    check("rst.st", 32'(dbg_state), 32'(RUN));

    // Free run: 0, 4, 8, 12
    rst_n = 1;
    step(); check("run0.pc", pc, 32'h0); check("run0.fv", 32'(fetch_valid), 32'd1);
    step(); check("run1.pc", pc, 32'h4);
    step(); check("run2.pc", pc, 32'h8);
    step(); check("run3.pc", pc, 32'hC);

    // JR to 0x400; decode inputs kept live (different target) during flush
    drive_jr(32'h0000_0400);
    step(); chk_out("jr.t1", 32'h400, 1, 1, 1, 0);
    rs_data = 32'h0000_0800;
    step(); chk_out("jr.t2", 32'h404, 1, 0, 0, 0);
    step(); chk_out("jr.t3", 32'h408, 0, 0, 0, 0);
    check("jr.t3.st", 32'(dbg_state), 32'(RUN));
    clr_id();
    step(); check("jr.t4.pc", pc, 32'h40C);

    // J with a taken branch also asserted: J wins
    id_valid = 1; Jump = 1; id_pc = 32'h1000_0010; jump_index = 26'h000_0040;
    Branch = 1; Zero = 1; branch_offset = 16'h0010;
    step(); chk_out("j.t1", 32'h1000_0100, 1, 1, 0, 0);
    clr_id();
    step(); chk_out("j.t2", 32'h1000_0104, 1, 0, 0, 0);
    step(); chk_out("j.t3", 32'h1000_0108, 0, 0, 0, 0);

    // BEQ taken, backward offset: 0x24 - 8 = 0x1C
    id_valid = 1; Branch = 1; Zero = 1; id_pc = 32'h20; branch_offset = 16'hFFFE;
    step(); chk_out("beq.t1", 32'h1C, 1, 1, 0, 0);
    clr_id();
    step(); step(); chk_out("beq.t3", 32'h24, 0, 0, 0, 0);

    // BEQ not taken: sequential
    id_valid = 1; Branch = 1; Zero = 0; id_pc = 32'h20; branch_offset = 16'hFFFE;
    step(); chk_out("beqnt", 32'h28, 0, 0, 0, 0);

    // Stall holds pc and blocks the JR; release -> redirect next cycle
    drive_jr(32'h0000_0400); stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out($sformatf("stall%0d", i), 32'h28, 0, 0, 0, 0);
    end
    stall_in = 0;
    step(); chk_out("unstall", 32'h400, 1, 1, 1, 0);
    clr_id();
    step(); step(); check("unstall.pc", pc, 32'h408);

    // Misaligned JR: low bits dropped, error pulses once
    drive_jr(32'h0000_0403);
    step(); chk_out("mis.t1", 32'h400, 1, 1, 1, 1);
    clr_id();
    step(); chk_out("mis.t2", 32'h404, 1, 0, 0, 0);
    step(); chk_out("mis.t3", 32'h408, 0, 0, 0, 0);

    // Redirect with imem_ready=0 still loads pc; pc holds until ready
    imem_ready = 0;
    id_valid = 1; Jump = 1; id_pc = 32'h0; jump_index = 26'h80;
    step(); chk_out("nrdy.t1", 32'h200, 1, 1, 0, 0);
    clr_id();
    step(); chk_out("nrdy.t2", 32'h200, 1, 0, 0, 0);
    imem_ready = 1;
    step(); chk_out("nrdy.t3", 32'h204, 0, 0, 0, 0);

    // PC wrap at 0xFFFF_FFFC
    drive_jr(32'hFFFF_FFFC);
    step(); chk_out("wrap.t1", 32'hFFFF_FFFC, 1, 1, 1, 0);
    clr_id();
    step(); chk_out("wrap.t2", 32'h0, 1, 0, 0, 0);
    step(); chk_out("wrap.t3", 32'h4, 0, 0, 0, 0);

    // Reset mid-flush
    drive_jr(32'h0000_0400);
    step(); chk_out("mrst.t1", 32'h400, 1, 1, 1, 0);
    rst_n = 0; clr_id();
    step(); chk_out("mrst.t2", 32'h0, 0, 0, 0, 0);
    check("mrst.fv", 32'(fetch_valid), 32'd0);
    check("mrst.st", 32'(dbg_state), 32'(RUN));
    rst_n = 1;
    step(); check("mrst.t3.pc", pc, 32'h0); check("mrst.t3.fv", 32'(fetch_valid), 32'd1);
    step(); check("mrst.t4.pc", pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
